// File: rtl/alu_operand_fetch_pkg.sv
// Shared definitions for the ALU operand-fetch stage: IR field layout, opcodes, stage state.
// Build option ALU_OPFETCH_WB_BYPASS_EN is consumed by alu_operand_fetch.
package alu_operand_fetch_pkg;

    localparam int SR_LSB    = 3;
    localparam int TR_LSB    = 0;
    localparam int REG_IDX_W = 3;

    localparam logic [15:0] OP_ADD = 16'h0001;
    localparam logic [15:0] OP_SUB = 16'h0002;
    localparam logic [15:0] OP_AND = 16'h0003;
    localparam logic [15:0] OP_OR  = 16'h0004;
    localparam logic [15:0] OP_XOR = 16'h0005;
    localparam logic [15:0] OP_MOV = 16'h0006;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/alu_regfile.sv
// General register file: NREG x DATA_W, two asynchronous read ports, one synchronous
// write port, cleared by synchronous active-low reset (reset wins over a write).
module alu_regfile
    import alu_operand_fetch_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [REG_IDX_W-1:0] raddr_a,
    output logic [DATA_W-1:0]    rdata_a,
    input  logic [REG_IDX_W-1:0] raddr_b,
    output logic [DATA_W-1:0]    rdata_b
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
            if (we && (waddr == REG_IDX_W'(i))) begin
                regs_d[i] = wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign rdata_a = regs_q[raddr_a];
    assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/alu_operand_fetch.sv
// Operand-fetch stage: one registered bundle {ir, sr, tr} with valid/ready on both sides.
// ALU_OPFETCH_WB_BYPASS_EN enables writeback bypass and held-operand refresh; otherwise a RAW stall.
module alu_operand_fetch
    import alu_operand_fetch_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_ir,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_ir,
    output logic [DATA_W-1:0]    out_sr,
    output logic [DATA_W-1:0]    out_tr,
    input  logic                 wb_en,
    input  logic [REG_IDX_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]    wb_data
);

    fetch_state_e        state_q, state_d;
    logic [31:0]         ir_q, ir_d;
    logic [DATA_W-1:0]   sr_q, sr_d;
    logic [DATA_W-1:0]   tr_q, tr_d;

    logic [REG_IDX_W-1:0] sr_idx, tr_idx;
    logic [DATA_W-1:0]    rf_sr, rf_tr;
    logic [DATA_W-1:0]    sr_fetch, tr_fetch;
    logic                 accept, consume;

    assign sr_idx = in_ir[SR_LSB +: REG_IDX_W];
    assign tr_idx = in_ir[TR_LSB +: REG_IDX_W];

    alu_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (sr_idx),
        .rdata_a (rf_sr),
        .raddr_b (tr_idx),
        .rdata_b (rf_tr)
    );

    assign out_valid = (state_q == ST_FULL);
    assign out_ir    = ir_q;
    assign out_sr    = sr_q;
    assign out_tr    = tr_q;

`ifdef ALU_OPFETCH_WB_BYPASS_EN
    assign in_ready = !out_valid || out_ready;
    assign sr_fetch = (wb_en && (wb_addr == sr_idx)) ? wb_data : rf_sr;
    assign tr_fetch = (wb_en && (wb_addr == tr_idx)) ? wb_data : rf_tr;
`else
    // Hold off one cycle so the instruction reads the register after the write lands.
    logic raw_hazard;
    assign raw_hazard = wb_en && in_valid && ((wb_addr == sr_idx) || (wb_addr == tr_idx));
    assign in_ready   = (!out_valid || out_ready) && !raw_hazard;
    assign sr_fetch   = rf_sr;
    assign tr_fetch   = rf_tr;
`endif

    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        sr_d    = sr_q;
        tr_d    = tr_q;
        if (accept) begin
            state_d = ST_FULL;
            ir_d    = in_ir;
            sr_d    = sr_fetch;
            tr_d    = tr_fetch;
        end else if (consume) begin
            state_d = ST_EMPTY;
        end
`ifdef ALU_OPFETCH_WB_BYPASS_EN
        else if (out_valid && wb_en) begin
            if (wb_addr == ir_q[SR_LSB +: REG_IDX_W]) sr_d = wb_data;
            if (wb_addr == ir_q[TR_LSB +: REG_IDX_W]) tr_d = wb_data;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            ir_q    <= '0;
            sr_q    <= '0;
            tr_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            sr_q    <= sr_d;
            tr_q    <= tr_d;
        end
    end

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Bench for alu_operand_fetch: directed vector table followed by randomized traffic
// checked against a register-array/bundle reference model.
module tb_alu_operand_fetch;
    import alu_operand_fetch_pkg::*;

`ifdef ALU_OPFETCH_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_ir;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ir;
    logic [31:0] out_sr;
    logic [31:0] out_tr;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [31:0] wb_data;

    always #5 clk = ~clk;

    alu_operand_fetch #(
        .DATA_W (32),
        .NREG   (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ir     (in_ir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ir    (out_ir),
        .out_sr    (out_sr),
        .out_tr    (out_tr),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        rst_n;
        logic        in_valid;
        logic [31:0] in_ir;
        logic        out_ready;
        logic        wb_en;
        logic [2:0]  wb_addr;
        logic [31:0] wb_data;
        logic        chk_rdy;
        logic        exp_rdy;
        logic        exp_valid;
        logic [31:0] exp_ir;
        logic [31:0] exp_sr;
        logic [31:0] exp_tr;
    } vec_t;

    vec_t tbl[$];

    // Reference model: register array plus the one bundle the stage may hold.
    logic [31:0] m_rf [8];
    logic        m_valid;
    logic [31:0] m_ir, m_sr, m_tr;

    function automatic logic [31:0] mk_ir(input logic [15:0] op, input int s, input int t);
        logic [31:0] r;
        r       = '0;
        r[31:16] = op;
        r[5:3]  = s[2:0];
        r[2:0]  = t[2:0];
        return r;
    endfunction

    function automatic logic m_ready();
        logic r;
        r = !m_valid || out_ready;
        if (!BYP && wb_en && in_valid && (wb_addr == in_ir[5:3] || wb_addr == in_ir[2:0]))
            r = 1'b0;
        return r;
    endfunction

    task automatic m_step();
        logic rdy;
        rdy = m_ready();
        if (!rst_n) begin
            m_valid = 1'b0;
            m_ir = '0; m_sr = '0; m_tr = '0;
            for (int i = 0; i < 8; i++) m_rf[i] = '0;
            return;
        end
        if (in_valid && rdy) begin
            m_valid = 1'b1;
            m_ir    = in_ir;
            m_sr    = (BYP && wb_en && wb_addr == in_ir[5:3]) ? wb_data : m_rf[in_ir[5:3]];
            m_tr    = (BYP && wb_en && wb_addr == in_ir[2:0]) ? wb_data : m_rf[in_ir[2:0]];
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end else if (m_valid && BYP && wb_en) begin
            if (wb_addr == m_ir[5:3]) m_sr = wb_data;
            if (wb_addr == m_ir[2:0]) m_tr = wb_data;
        end
        if (wb_en) m_rf[wb_addr] = wb_data;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic iv, input logic [31:0] ir, input logic ordy,
                       input logic we, input logic [2:0] wa, input logic [31:0] wd,
                       input logic crdy, input logic erdy, input logic ev,
                       input logic [31:0] eir, input logic [31:0] esr, input logic [31:0] etr);
        vec_t v;
        v.rst_n = r; v.in_valid = iv; v.in_ir = ir; v.out_ready = ordy;
        v.wb_en = we; v.wb_addr = wa; v.wb_data = wd;
        v.chk_rdy = crdy; v.exp_rdy = erdy; v.exp_valid = ev;
        v.exp_ir = eir; v.exp_sr = esr; v.exp_tr = etr;
        tbl.push_back(v);
    endtask

    initial begin
        logic [31:0] i0, i1, i2, i3, i4, ix, iw, is, ir1, ir2;
        i0  = mk_ir(OP_ADD, 5, 3);
        i1  = mk_ir(OP_SUB, 3, 5);
        i2  = mk_ir(OP_AND, 5, 5);
        i3  = mk_ir(OP_OR,  0, 3);
        i4  = mk_ir(OP_XOR, 1, 2);
        ix  = mk_ir(OP_ADD, 3, 3);
        iw  = mk_ir(OP_MOV, 2, 2);
        is  = mk_ir(OP_SUB, 2, 4);
        ir1 = mk_ir(OP_AND, 4, 2);
        ir2 = mk_ir(OP_OR,  5, 3);

        rst_n = 1'b0; in_valid = 1'b0; in_ir = '0; out_ready = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;

        // rst, iv, ir, ordy, we, wa, wd, chk_rdy, exp_rdy, exp_valid, exp_ir, exp_sr, exp_tr
        add(0, 0, 0,   0, 0, 0, 0,             0, 0, 0, 0,  0, 0);
        add(1, 0, 0,   1, 1, 3, 32'h12345678,  1, 1, 0, 0,  0, 0);
        add(1, 0, 0,   1, 1, 5, 32'hCAFEBABE,  1, 1, 0, 0,  0, 0);
        add(1, 1, i0,  1, 0, 0, 0,             1, 1, 1, i0, 32'hCAFEBABE, 32'h12345678);
        add(1, 1, i1,  1, 0, 0, 0,             1, 1, 1, i1, 32'h12345678, 32'hCAFEBABE);
        add(1, 1, i2,  1, 0, 0, 0,             1, 1, 1, i2, 32'hCAFEBABE, 32'hCAFEBABE);
        add(1, 1, i3,  1, 0, 0, 0,             1, 1, 1, i3, 0, 32'h12345678);
        add(1, 1, i4,  1, 0, 0, 0,             1, 1, 1, i4, 0, 0);
        for (int k = 0; k < 3; k++)
            add(1, 1, ix, 0, 0, 0, 0,          1, 0, 1, i4, 0, 0);
        add(1, 1, ix,  1, 0, 0, 0,             1, 1, 1, ix, 32'h12345678, 32'h12345678);
        add(1, 0, 0,   1, 0, 0, 0,             1, 1, 0, ix, 32'h12345678, 32'h12345678);
        add(1, 1, iw,  1, 1, 2, 32'hDEADBEEF,  1, BYP, BYP, BYP ? iw : ix,
            BYP ? 32'hDEADBEEF : 32'h12345678, BYP ? 32'hDEADBEEF : 32'h12345678);
        add(1, 1, iw,  1, 0, 0, 0,             1, 1, 1, iw, 32'hDEADBEEF, 32'hDEADBEEF);
        add(1, 1, is,  1, 0, 0, 0,             1, 1, 1, is, 32'hDEADBEEF, 0);
        add(1, 0, 0,   0, 1, 4, 32'h0000FFFF,  1, 0, 1, is, 32'hDEADBEEF, BYP ? 32'h0000FFFF : 0);
        add(1, 0, 0,   0, 0, 0, 0,             1, 0, 1, is, 32'hDEADBEEF, BYP ? 32'h0000FFFF : 0);
        add(0, 0, 0,   0, 1, 4, 32'hAAAA5555,  1, 0, 0, 0,  0, 0);
        add(1, 1, ir1, 1, 0, 0, 0,             1, 1, 1, ir1, 0, 0);
        add(1, 1, ir2, 1, 0, 0, 0,             1, 1, 1, ir2, 0, 0);

        foreach (tbl[n]) begin
            rst_n = tbl[n].rst_n; in_valid = tbl[n].in_valid; in_ir = tbl[n].in_ir;
            out_ready = tbl[n].out_ready; wb_en = tbl[n].wb_en;
            wb_addr = tbl[n].wb_addr; wb_data = tbl[n].wb_data;
            #1;
            if (tbl[n].chk_rdy) chk($sformatf("vec%0d in_ready", n), 32'(in_ready), 32'(tbl[n].exp_rdy));
            m_step();
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d out_valid", n), 32'(out_valid), 32'(tbl[n].exp_valid));
            chk($sformatf("vec%0d out_ir", n), out_ir, tbl[n].exp_ir);
            chk($sformatf("vec%0d out_sr", n), out_sr, tbl[n].exp_sr);
            chk($sformatf("vec%0d out_tr", n), out_tr, tbl[n].exp_tr);
            $display("[TB] vec %0d: valid=%0b ir=%h sr=%h tr=%h", n, out_valid, out_ir, out_sr, out_tr);
        end

        for (int c = 0; c < 300; c++) begin
            rst_n     = ($urandom_range(0, 59) != 0);
            in_valid  = $urandom_range(0, 3) != 0;
            in_ir     = $urandom;
            out_ready = $urandom_range(0, 9) < 7;
            wb_en     = $urandom_range(0, 1);
            wb_addr   = 3'($urandom_range(0, 7));
            wb_data   = $urandom;
            #1;
            chk($sformatf("rnd%0d in_ready", c), 32'(in_ready), 32'(m_ready()));
            m_step();
            @(posedge clk);
            #1;
            chk($sformatf("rnd%0d out_valid", c), 32'(out_valid), 32'(m_valid));
            chk($sformatf("rnd%0d out_ir", c), out_ir, m_ir);
            chk($sformatf("rnd%0d out_sr", c), out_sr, m_sr);
            chk($sformatf("rnd%0d out_tr", c), out_tr, m_tr);
            $display("[TB] rnd %0d: rst_n=%0b valid=%0b ir=%h sr=%h tr=%h",
                     c, rst_n, out_valid, out_ir, out_sr, out_tr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_operand_fetch.md
Name: alu_operand_fetch

Overview:
- Pipeline stage that produces the ALU's operand bundle: instruction word, source operand (sr) and target operand (tr).
- Sits between instruction decode and the combinational ALU.
- Owns the 8x32 general register file.
- Accepts the writeback stream, i.e. the ALU result returning to the register file.
- Valid/ready handshake on both the upstream and downstream sides; one registered output stage.

Parameters:
- DATA_W, 32, operand/register width
- NREG, 8, number of general registers (index width = clog2(NREG) = 3)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  decode offers an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_ir  in  32  instruction word: opcode ir[31:16], sr index ir[5:3], tr index ir[2:0]
- out_valid  out  1  operand bundle valid
- out_ready  in  1  ALU/execute consumes the bundle
- out_ir  out  32  registered instruction word
- out_sr  out  DATA_W  registered value of register ir[5:3]
- out_tr  out  DATA_W  registered value of register ir[2:0]
- wb_en  in  1  register writeback strobe
- wb_addr  in  3  writeback register index
- wb_data  in  DATA_W  writeback value (ALU dr or load data)

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - out_valid=0, out_ir=0, out_sr=0, out_tr=0.
  - All NREG registers cleared to 0.
  - Writeback ignored during the reset cycle.
  - Reset mid-transfer discards the held bundle.
- in_ready = !out_valid || out_ready. This is combinational; no bubble on a continuous stream.
- Accept (in_valid && in_ready):
  - Next edge: out_valid=1, out_ir=in_ir.
  - out_sr=RF[in_ir[5:3]], out_tr=RF[in_ir[2:0]].
  - Latency is 1 cycle from accept to out_valid.
- Drain: out_ready && !accept -> out_valid=0 next edge. out_ir/out_sr/out_tr hold their last values (not cleared).
- Stall: out_valid && !out_ready -> out_ir, out_sr and out_tr stable, except the held-operand refresh below.
- Writeback: wb_en=1 -> RF[wb_addr]<=wb_data at the edge. No register is hardwired to zero.
- Simultaneous accept and writeback to a read index: the captured operand is wb_data (same-cycle bypass). Applies to sr and tr independently; both get wb_data if both indices match.
- Held-operand refresh: while stalled, wb_en with wb_addr == out_ir[5:3] (or [2:0]) updates out_sr (or out_tr) to wb_data. The held bundle therefore never goes stale.
- Consumed on the same edge as a writeback: the bundle goes out and no refresh is needed. A newly accepted instruction still gets the bypass.
- Both the refresh and the bypass rules depend on WB_BYPASS_EN (see Optional Feature).
- No internal state machine beyond the valid flag: two states, EMPTY and FULL.
  - EMPTY -> FULL on accept.
  - FULL -> FULL on stall, or on consume+accept.
  - FULL -> EMPTY on consume without accept.

Optional Feature:
- Macro: ALU_OPFETCH_WB_BYPASS_EN.
- Defined:
  - Same-cycle writeback-to-read bypass is active.
  - Held-operand refresh is active.
- Undefined:
  - Reads return the pre-edge RF contents.
  - Held operands are never refreshed.
  - in_ready is deasserted for one cycle whenever wb_en && in_valid && wb_addr matches in_ir[5:3] or in_ir[2:0]. This is a structural stall so the next cycle reads the written value.
  - Stall-refresh hazards are the scheduler's responsibility.

Decomposition:
- Shared header holds:
  - IR field positions: SR_LSB=3, TR_LSB=0, REG_IDX_W=3.
  - The opcode constants already used by the ALU and decoder.
- One sub-module: alu_regfile. It holds NREG x DATA_W storage, 2 asynchronous read ports, 1 synchronous write port, and the synchronous reset clear. Bypass muxing stays in alu_operand_fetch.

Test Plan:
- Reset, then write RF[3]=0x12345678 and RF[5]=0xCAFEBABE; send ir with sr=5, tr=3 -> next cycle out_valid=1, out_sr=0xCAFEBABE, out_tr=0x12345678, out_ir echoed.
- out_ready=1 with back-to-back in_valid for 4 instructions -> in_ready stays 1, one bundle per cycle in order, no bubbles.
- Hold out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0, outputs frozen. Release -> the next instruction is captured the same edge the held bundle is consumed.
- Same-cycle wb_en, wb_addr=2, wb_data=0xDEADBEEF with an accept of sr=2, tr=2:
  - Bypass defined: out_sr=out_tr=0xDEADBEEF.
  - Bypass undefined: a 1-cycle in_ready drop, then 0xDEADBEEF.
- Stalled bundle with tr=4 and writeback RF[4]=0x0000FFFF -> out_tr becomes 0x0000FFFF next cycle, out_sr unchanged (bypass defined).
- Assert rst_n=0 while FULL and stalled -> next edge out_valid=0, all outputs 0, and a read of any register returns 0.
